forwarding_unit_pipe: RTL

Parametrised successor to the two-stage ALU bypass mux. It owns a registered destination-tag pipeline that tracks DEPTH in-flight producer stages after EX. It forwards operands for NUM_SRC source ports, giving the youngest producer priority. It detects load-use hazards and inserts its own bubble. It sits beside the EX stage and takes per-stage result data from the datapath.

---
 rtl/fwd_pkg.sv | 31 +++
 rtl/fwd_tag_pipe.sv | 33 +++
 rtl/forwarding_unit_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// ----------------------------------------------------------------------------
// fwd_pkg
// Shared types and helpers for the operand forwarding unit.
//   fwd_tag_t    : destination tag tracked per producer stage
//   TAG_RD_W     : storage width of the rd field (REG_AW must not exceed it)
//   FWD_SEL_NONE : all-ones marker for "no producer selected"
//   fwd_clog2    : ceil(log2(n)), sizes the selected-stage index
// ----------------------------------------------------------------------------
package fwd_pkg;

   localparam int unsigned TAG_RD_W = 8;

   typedef struct packed {
      logic                valid;
      logic [TAG_RD_W-1:0] rd;
      logic                we;
      logic                is_load;
   } fwd_tag_t;

   // Truncated to the index width, all-ones is always >= DEPTH, so it can
   // never collide with a real stage index.
   localparam logic [31:0] FWD_SEL_NONE = '1;

   function automatic int unsigned fwd_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = 1; v < n; v = v << 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// ----------------------------------------------------------------------------
// fwd_tag_pipe
// DEPTH-entry destination-tag shift register. Entry 0 is the youngest
// producer (EX/MEM), entry DEPTH-1 the oldest; the oldest retires on advance.
//   clk, rst_n : clock, asynchronous active-low reset (all tags cleared)
//   adv        : 1 = shift and load in_tag into entry 0, 0 = hold all entries
//   in_tag     : tag (or bubble) entering entry 0
//   tags       : current tag of every tracked stage
// ----------------------------------------------------------------------------
module fwd_tag_pipe
   import fwd_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 adv,
   input  fwd_tag_t             in_tag,
   output fwd_tag_t [DEPTH-1:0] tags
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tags <= '0;
      end else if (adv) begin
         tags[0] <= in_tag;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            tags[k] <= tags[k-1];
         end
      end
   end

endmodule

// File: rtl/forwarding_unit_pipe.sv
// ----------------------------------------------------------------------------
// forwarding_unit_pipe
// EX-stage operand bypass for NUM_SRC sources over DEPTH tracked producer
// stages, youngest producer first, with load-use hazard detection and
// self-inserted bubble.
//   clk, rst_n      : clock, asynchronous active-low reset
//   adv             : pipeline advance (0 = tags frozen)
//   flush           : squash the EX instruction (bubble into stage 0)
//   ex_valid/ex_rd/ex_reg_write/ex_is_load : EX instruction tag
//   src_addr        : consumer source addresses, port i at [i*REG_AW +: REG_AW]
//   reg_data        : register-file read data per source
//   stage_data      : producer result of stage k at [k*DATA_W +: DATA_W]
//   fwd_data        : resolved operand per source
//   fwd_hit         : operand i was taken from a producer stage
//   load_use_stall  : consumer must hold, bubble inserted
// Optional (macro FWD_PERF_EN):
//   perf_clr        : synchronous clear of both counters
//   perf_stall_cnt  : saturating count of cycles with load_use_stall & adv
//   perf_fwd_cnt    : saturating count of cycles with any fwd_hit & adv
// ----------------------------------------------------------------------------
module forwarding_unit_pipe
   import fwd_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      adv,
   input  logic                      flush,
   input  logic                      ex_valid,
   input  logic [REG_AW-1:0]         ex_rd,
   input  logic                      ex_reg_write,
   input  logic                      ex_is_load,
   input  logic [NUM_SRC*REG_AW-1:0] src_addr,
   input  logic [NUM_SRC*DATA_W-1:0] reg_data,
   input  logic [DEPTH*DATA_W-1:0]   stage_data,
   output logic [NUM_SRC*DATA_W-1:0] fwd_data,
   output logic [NUM_SRC-1:0]        fwd_hit,
   output logic                      load_use_stall
`ifdef FWD_PERF_EN
   ,
   input  logic                      perf_clr,
   output logic [31:0]               perf_stall_cnt,
   output logic [31:0]               perf_fwd_cnt
`endif
);

   localparam int unsigned SEL_W = fwd_clog2(DEPTH + 1);
   localparam logic [SEL_W-1:0] SEL_NONE = FWD_SEL_NONE[SEL_W-1:0];

   if (LOAD_LAT >= DEPTH) begin : g_bad_load_lat
      $error("forwarding_unit_pipe: LOAD_LAT must be smaller than DEPTH");
   end
   if (REG_AW > TAG_RD_W) begin : g_bad_reg_aw
      $error("forwarding_unit_pipe: REG_AW exceeds TAG_RD_W");
   end

   fwd_tag_t [DEPTH-1:0] tags;
   fwd_tag_t             in_tag;
   logic [NUM_SRC-1:0]   unready;

   always_comb begin
      in_tag = '0;
      if (ex_valid && !flush && !load_use_stall) begin
         in_tag.valid   = 1'b1;
         in_tag.rd      = TAG_RD_W'(ex_rd);
         in_tag.we      = ex_reg_write;
         in_tag.is_load = ex_is_load;
      end
   end

   fwd_tag_pipe #(
      .DEPTH (DEPTH)
   ) u_tag_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv),
      .in_tag (in_tag),
      .tags   (tags)
   );

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_AW-1:0] src;
      logic [DATA_W-1:0] reg_val;
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] sel_data;
      logic              sel_early_ld;
      logic              found;

      assign src     = src_addr[i*REG_AW +: REG_AW];
      assign reg_val = reg_data[i*DATA_W +: DATA_W];

      // Only the youngest match is considered; an unready load there blocks
      // any older producer of the same register.
      always_comb begin
         sel          = SEL_NONE;
         sel_data     = '0;
         sel_early_ld = 1'b0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (sel == SEL_NONE && tags[k].valid && tags[k].we &&
                tags[k].rd == TAG_RD_W'(src) && src != '0) begin
               sel          = SEL_W'(k);
               sel_data     = stage_data[k*DATA_W +: DATA_W];
               sel_early_ld = tags[k].is_load && (k < LOAD_LAT);
            end
         end
      end

      assign found      = (sel != SEL_NONE);
      assign unready[i] = found && sel_early_ld;
      assign fwd_hit[i] = found && !sel_early_ld;
      assign fwd_data[i*DATA_W +: DATA_W] = fwd_hit[i] ? sel_data : reg_val;
   end

   assign load_use_stall = |unready;

`ifdef FWD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else if (perf_clr) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else begin
         if (load_use_stall && adv && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if ((|fwd_hit) && adv && perf_fwd_cnt != '1)
            perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
   end
`endif

endmodule
